// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS 32-bit software-to-fabric control registers,
// with optional shadow+commit so multi-word settings reach the fabric in one cycle.

module opb_reg_lane #(
  parameter bit          ATOMIC    = 1'b1,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        wr_en,
  input  logic        commit,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] shadow_q,
  output logic [31:0] out_q,
  output logic        pending_q,
  output logic        update_q
);
  logic [31:0] merged, shadow_d, out_d;
  logic        pending_d, update_d;

  always_comb begin
    merged = shadow_q;
    for (int b = 0; b < 4; b++)
      if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    shadow_d  = shadow_q;
    out_d     = out_q;
    pending_d = pending_q;
    update_d  = 1'b0;
    if (wr_en && |be) begin
      shadow_d = merged;
      if (ATOMIC) pending_d = 1'b1;
      else begin
        out_d    = merged;
        update_d = 1'b1;
      end
    end else if (commit && pending_q) begin
      out_d     = shadow_q;
      update_d  = 1'b1;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      shadow_q  <= RESET_VAL;
      out_q     <= RESET_VAL;
      pending_q <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      out_q     <= out_d;
      pending_q <= pending_d;
      update_q  <= update_d;
    end
  end
endmodule

module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01083900,
  parameter logic [31:0] C_HIGHADDR   = 32'h010839FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 8,
  parameter bit          C_ATOMIC     = 1'b1,
  parameter logic [31:0] C_RESET_VAL  = 32'h00000000,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:31]             OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:31]             OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:31]             Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0] user_data_out,
  output logic [C_NUM_REGS-1:0]   user_update
);
  localparam int IW = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
  localparam bit unused_family = (C_FAMILY == "virtex6");

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;
  state_t state_q;

  // Numeric views of the big-endian OPB buses: OPB bit 0 becomes bit 31.
  logic [C_OPB_AWIDTH-1:0] addr;
  logic [C_OPB_DWIDTH-1:0] wdata, rd_data, dbus_q;
  logic [3:0]              be;
  logic [31:0]             offset, widx, status;
  logic [63:0]             pend_pad;
  logic                    hit, wr_hit, commit, ack_q;
  logic [C_NUM_REGS-1:0]   reg_wr, pending;
  logic [C_NUM_REGS-1:0][31:0] shadow;
  logic                    unused_in;

  assign addr      = OPB_ABus;
  assign wdata     = OPB_DBus;
  assign be        = OPB_BE;
  assign offset    = addr - C_BASEADDR;
  assign widx      = {2'b00, offset[31:2]};
  assign unused_in = ^{OPB_seqAddr, offset[1:0], pend_pad[63:32], unused_family};

  assign hit    = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign wr_hit = (state_q == S_IDLE) && hit && !OPB_RNW;
  assign commit = C_ATOMIC && wr_hit && (widx == 32'(C_NUM_REGS));

  always_comb begin
    reg_wr = '0;
    for (int i = 0; i < C_NUM_REGS; i++)
      reg_wr[i] = wr_hit && (widx == 32'(i));
    pend_pad = 64'(pending);
    status   = pend_pad[31:0];
    rd_data  = '0;
    if (widx < 32'(C_NUM_REGS))           rd_data = shadow[widx[IW-1:0]];
    else if (widx == 32'(C_NUM_REGS + 1)) rd_data = status;
  end

  opb_reg_lane #(.ATOMIC(C_ATOMIC), .RESET_VAL(C_RESET_VAL)) u_lane [C_NUM_REGS-1:0] (
    .gclk      (OPB_Clk),
    .grst_n    (OPB_Rst_n),
    .wr_en     (reg_wr),
    .commit    (commit),
    .be        (be),
    .wdata     (wdata),
    .shadow_q  (shadow),
    .out_q     (user_data_out),
    .pending_q (pending),
    .update_q  (user_update)
  );

  // WAIT holds off a second ack until the master releases select.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      dbus_q  <= '0;
    end else begin
      ack_q  <= 1'b0;
      dbus_q <= '0;
      case (state_q)
        S_IDLE: if (hit) begin
          state_q <= S_ACK;
          ack_q   <= 1'b1;
          if (OPB_RNW) dbus_q <= rd_data;
        end
        S_ACK:  state_q <= S_WAIT;
        S_WAIT: if (!OPB_select) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Sl_DBus    = dbus_q;
  assign Sl_xferAck = ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Drives one OPB stream into an atomic (a) and a direct-update (d) register bank
// and checks both against a transaction-level model every cycle.

module tb_opb_register_bank_ppc2simulink;
  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h01083900;
  localparam logic [31:0] HIGH = 32'h010839FF;
  localparam logic [31:0] RV   = 32'hA5A5A5A5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] abus = '0, dbus = '0;
  logic [0:3]  be_i = '0;
  logic rnw = 1'b0, sel = 1'b0, seq = 1'b0;

  logic [31:0]  sdb_a, sdb_d;
  logic         sack_a, sack_d, err_a, err_d, rty_a, rty_d, to_a, to_d;
  logic [255:0] udo_a, udo_d;
  logic [7:0]   upd_a, upd_d;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(.C_NUM_REGS(N), .C_ATOMIC(1'b1), .C_RESET_VAL(RV)) dut_a (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be_i), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(sdb_a), .Sl_xferAck(sack_a),
    .Sl_errAck(err_a), .Sl_retry(rty_a), .Sl_toutSup(to_a), .user_data_out(udo_a), .user_update(upd_a));

  opb_register_bank_ppc2simulink #(.C_NUM_REGS(N), .C_ATOMIC(1'b0), .C_RESET_VAL(RV)) dut_d (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be_i), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(sdb_d), .Sl_xferAck(sack_d),
    .Sl_errAck(err_d), .Sl_retry(rty_d), .Sl_toutSup(to_d), .user_data_out(udo_d), .user_update(upd_d));

  int checks = 0, failures = 0, ack_cnt = 0;
  logic chk_en = 1'b0;

  // model: index 0 = atomic bank, 1 = direct bank
  logic [31:0] m_sh [2][N];
  logic [31:0] m_out[2][N];
  logic [7:0]  m_pend[2];
  logic        exp_ack;
  logic [31:0] exp_db[2];
  logic [7:0]  exp_upd[2];

  task automatic cmp(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] pk(input int m);
    logic [255:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = m_out[m][i];
    return v;
  endfunction

  task automatic clear_exp();
    exp_ack = 1'b0;
    for (int m = 0; m < 2; m++) begin exp_db[m] = '0; exp_upd[m] = '0; end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) begin m_sh[m][i] = RV; m_out[m][i] = RV; end
      m_pend[m] = '0;
    end
    clear_exp();
  endtask

  task automatic m_access(input logic [31:0] a, input logic r, input logic [0:3] b, input logic [31:0] d);
    int w;
    logic [31:0] t;
    w = int'((a - BASE) >> 2);
    exp_ack = 1'b1;
    for (int m = 0; m < 2; m++) begin
      exp_db[m] = '0; exp_upd[m] = '0;
      if (r) begin
        if (w < N)          exp_db[m] = m_sh[m][w];
        else if (w == N+1)  exp_db[m] = {24'h0, m_pend[m]};
      end else if (w < N) begin
        if (b != 4'b0000) begin
          t = m_sh[m][w];
          for (int k = 0; k < 4; k++) if (b[k]) t[31-8*k -: 8] = d[31-8*k -: 8];
          m_sh[m][w] = t;
          if (m == 0) m_pend[m][w] = 1'b1;
          else begin m_out[m][w] = t; exp_upd[m][w] = 1'b1; end
        end
      end else if (w == N && m == 0) begin
        exp_upd[m] = m_pend[m];
        for (int i = 0; i < N; i++) if (m_pend[m][i]) m_out[m][i] = m_sh[m][i];
        m_pend[m] = '0;
      end
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    if (sack_a) ack_cnt++;
    cmp("ack_a", 256'(sack_a), 256'(exp_ack));
    cmp("ack_d", 256'(sack_d), 256'(exp_ack));
    cmp("dbus_a", 256'(sdb_a), 256'(exp_db[0]));
    cmp("dbus_d", 256'(sdb_d), 256'(exp_db[1]));
    cmp("udo_a", udo_a, pk(0));
    cmp("udo_d", udo_d, pk(1));
    cmp("upd_a", 256'(upd_a), 256'(exp_upd[0]));
    cmp("upd_d", 256'(upd_d), 256'(exp_upd[1]));
    cmp("tied0", 256'({err_a, rty_a, to_a, err_d, rty_d, to_d}), 256'(0));
  end

  // Select held for `hold` cycles starting in cycle n; ack observed in cycle n+1.
  task automatic xfer(input logic [31:0] a, input logic r, input logic [0:3] b, input logic [31:0] d,
                      input int hold, output logic [31:0] rd_a, output logic [31:0] rd_d,
                      output logic ak, output logic [7:0] up_a, output logic [7:0] up_d);
    int last;
    logic hit;
    hit  = (a >= BASE) && (a <= HIGH);
    last = ((hold > 2) ? hold : 2) + 1;
    abus = a; rnw = r; be_i = b; dbus = d; sel = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      if (k == 1 && hit) m_access(a, r, b, d);
      else clear_exp();
      sel = (k < hold);
      if (k == 1) begin
        @(negedge clk);
        rd_a = sdb_a; rd_d = sdb_d; ak = sack_a; up_a = upd_a; up_d = upd_d;
      end
    end
  endtask

  logic [31:0] ra, rd;
  logic        ak;
  logic [7:0]  ua, ud;
  int          c0;

  initial begin
    model_reset();
    rst_n = 1'b0;
    @(posedge clk); #1 chk_en = 1'b1;
    @(negedge clk);
    cmp("rst_word0", 256'(udo_a[31:0]), 256'(RV));
    cmp("rst_word7", 256'(udo_d[255:224]), 256'(RV));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(BASE + 4*(N+1), 1'b1, 4'hF, 32'h0, 1, ra, rd, ak, ua, ud);
    cmp("rst_status", 256'({ra, rd}), 256'(0));

    xfer(BASE + 12, 1'b0, 4'hF, 32'h12345678, 1, ra, rd, ak, ua, ud);
    cmp("wr3_ack", 256'(ak), 256'(1));
    cmp("wr3_upd_d", 256'(ud), 256'(8'h08));
    cmp("wr3_upd_a", 256'(ua), 256'(0));
    cmp("wr3_word_d", 256'(udo_d[127:96]), 256'(32'h12345678));
    cmp("wr3_word_a", 256'(udo_a[127:96]), 256'(RV));
    xfer(BASE + 12, 1'b1, 4'hF, 32'h0, 1, ra, rd, ak, ua, ud);
    cmp("rd3", 256'({ra, rd}), 256'({32'h12345678, 32'h12345678}));

    xfer(BASE, 1'b0, 4'hF, 32'hFFFFFFFF, 1, ra, rd, ak, ua, ud);
    xfer(BASE, 1'b0, 4'b0101, 32'h00000000, 1, ra, rd, ak, ua, ud);
    xfer(BASE, 1'b1, 4'hF, 32'h0, 1, ra, rd, ak, ua, ud);
    cmp("be_merge", 256'({ra, rd}), 256'({32'hFF00FF00, 32'hFF00FF00}));

    xfer(BASE + 4*N, 1'b0, 4'hF, 32'h0, 1, ra, rd, ak, ua, ud);
    cmp("commit_09", 256'({ua, ud}), 256'({8'h09, 8'h00}));

    xfer(BASE + 4,  1'b0, 4'hF, 32'h11, 1, ra, rd, ak, ua, ud);
    cmp("atom_hold", 256'(ua), 256'(0));
    xfer(BASE + 20, 1'b0, 4'hF, 32'h55, 1, ra, rd, ak, ua, ud);
    xfer(BASE + 4*(N+1), 1'b1, 4'hF, 32'h0, 1, ra, rd, ak, ua, ud);
    cmp("status_22", 256'({ra, rd}), 256'({32'h22, 32'h0}));
    xfer(BASE + 4*N, 1'b0, 4'hF, 32'hCAFE, 1, ra, rd, ak, ua, ud);
    cmp("commit_22", 256'({ua, ud}), 256'({8'h22, 8'h00}));
    cmp("commit_w5", 256'(udo_a[191:160]), 256'(32'h55));
    xfer(BASE + 4*(N+1), 1'b1, 4'hF, 32'h0, 1, ra, rd, ak, ua, ud);
    cmp("status_clr", 256'(ra), 256'(0));
    xfer(BASE + 4*N, 1'b0, 4'hF, 32'h0, 1, ra, rd, ak, ua, ud);
    cmp("commit_empty", 256'({ak, ua}), 256'({1'b1, 8'h00}));

    xfer(BASE + 24, 1'b0, 4'b0000, 32'h66666666, 1, ra, rd, ak, ua, ud);
    cmp("be0_ack_upd", 256'({ak, ud}), 256'({1'b1, 8'h00}));
    xfer(BASE + 4*(N+1), 1'b1, 4'hF, 32'h0, 1, ra, rd, ak, ua, ud);
    cmp("be0_status", 256'(ra), 256'(0));

    xfer(BASE + 16 + 3, 1'b0, 4'hF, 32'h44444444, 1, ra, rd, ak, ua, ud);
    cmp("unaligned", 256'(ud), 256'(8'h10));

    c0 = ack_cnt;
    xfer(BASE + 4, 1'b1, 4'hF, 32'h0, 4, ra, rd, ak, ua, ud);
    cmp("hold_one_ack", 256'(ack_cnt - c0), 256'(1));
    cmp("hold_rd", 256'(ra), 256'(32'h11));

    xfer(BASE + 32'h100, 1'b1, 4'hF, 32'h0, 1, ra, rd, ak, ua, ud);
    cmp("miss_high", 256'(ak), 256'(0));
    xfer(BASE - 4, 1'b0, 4'hF, 32'h0, 1, ra, rd, ak, ua, ud);
    cmp("miss_low", 256'(ak), 256'(0));
    xfer(BASE + 4*20, 1'b1, 4'hF, 32'h0, 1, ra, rd, ak, ua, ud);
    cmp("past_status", 256'({ak, ra}), 256'({1'b1, 32'h0}));
    xfer(BASE + 4*20, 1'b0, 4'hF, 32'h77777777, 1, ra, rd, ak, ua, ud);

    // reset asserted during the ACK cycle of a write to REG[2]
    abus = BASE + 8; rnw = 1'b0; be_i = 4'hF; dbus = 32'hDEADBEEF; sel = 1'b1;
    @(posedge clk); #1;
    m_access(BASE + 8, 1'b0, 4'hF, 32'hDEADBEEF);
    #1 cmp("mid_ack_pre", 256'(sack_a), 256'(1));
    rst_n = 1'b0; sel = 1'b0;
    #1 cmp("mid_ack_drop", 256'({sack_a, sack_d}), 256'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(BASE + 8, 1'b1, 4'hF, 32'h0, 1, ra, rd, ak, ua, ud);
    cmp("post_rst_r2", 256'({ra, rd}), 256'({RV, RV}));
    xfer(BASE + 20, 1'b1, 4'hF, 32'h0, 1, ra, rd, ak, ua, ud);
    cmp("post_rst_r5", 256'(ra), 256'(RV));
    xfer(BASE + 4*(N+1), 1'b1, 4'hF, 32'h0, 1, ra, rd, ak, ua, ud);
    cmp("post_rst_status", 256'(ra), 256'(0));

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/opb_register_bank_ppc2simulink.md
# opb_register_bank_ppc2simulink

Multi-channel successor to the single OPB software-to-fabric register. It exposes C_NUM_REGS 32-bit control registers, each writable by the PowerPC over OPB with byte enables and readable back. An optional atomic mode holds writes in shadow registers until a commit write, so a multi-word setting (e.g. ADC input delay/phase for all lanes) reaches the fabric in a single cycle. The block sits on the OPB bus and drives fabric control inputs directly. Everything runs in the OPB clock domain, so there is no CDC inside.

## Interface
- C_BASEADDR, 32'h01083900, first byte address of the window
- C_HIGHADDR, 32'h010839FF, last byte address of the window; must cover 4*(C_NUM_REGS+2) bytes
- C_OPB_AWIDTH, 32, address width
- C_OPB_DWIDTH, 32, data width; only 32 is supported
- C_NUM_REGS, 8, number of user registers, range 1..62
- C_ATOMIC, 1, 1 = shadow+commit mode, 0 = direct-update mode
- C_RESET_VAL, 32'h00000000, reset value of every register
- C_FAMILY, "virtex6", passed through, unused

Ports:
- OPB_Clk  in  1  single clock for all logic
- OPB_Rst_n  in  1  reset; asynchronous assert, active-low; release is synchronous to OPB_Clk externally
- OPB_ABus  in  [0:31]  byte address
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7]
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  transfer request
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data; zero whenever Sl_xferAck=0
- Sl_xferAck  out  1  one-cycle transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1  tied 0
- user_data_out  out  [32*C_NUM_REGS-1:0]  register i sits in bits [32i+31:32i]; OPB bit 0 maps to bit 32i+31
- user_update  out  [C_NUM_REGS-1:0]  one-cycle pulse per register whose output changed source value

## Operation
- Address map, offsets from C_BASEADDR, word-aligned; ABus[30:31] are ignored:
  - 4*i: REG[i], for i < C_NUM_REGS
  - 4*C_NUM_REGS: COMMIT. A write of any data commits. A read returns 0.
  - 4*(C_NUM_REGS+1): STATUS. Read-only. Returns the pending mask in LSBs (DBus[31] = reg 0); other bits 0.
- Hit: OPB_select=1 and C_BASEADDR <= ABus <= C_HIGHADDR.
  - Hits above STATUS are acked, read 0, and writes are ignored.
  - Misses are never acked.
- FSM states: IDLE, ACK, WAIT.
  - IDLE -> ACK on a hit.
  - ACK lasts exactly one cycle with Sl_xferAck=1, then -> WAIT.
  - WAIT -> IDLE when OPB_select=0. This blocks a double-ack while select is still high.
- Write to REG[i]: each byte with BE set is merged into shadow[i]; other bytes are kept.
  - If BE=0000: acked, no state change, pending not set.
  - C_ATOMIC=0: user_data_out[i] is updated at the same edge and user_update[i] pulses.
  - C_ATOMIC=1: pending[i] is set; outputs are unchanged.
- COMMIT write with C_ATOMIC=1: for every pending i, user_data_out[i] <= shadow[i] and user_update[i] pulses. All pulses occur in the same cycle. Pending clears.
  - Commit with pending=0: acked, no pulses.
  - With C_ATOMIC=0, COMMIT is acked and has no effect.
- Read of REG[i] returns shadow[i], which is the latest written value, not necessarily committed.
- Reset, or reset asserted mid-transfer:
  - shadow and user_data_out = C_RESET_VAL
  - pending = 0, user_update = 0
  - Sl_* = 0, FSM = IDLE
  - An in-flight transfer is dropped without ack.

## Timing
- The hit is sampled at the edge ending cycle n. Sl_xferAck=1 and Sl_DBus are valid in cycle n+1 (registered).
- Writes take effect at the edge ending cycle n. user_data_out is new from cycle n+1, and user_update pulses in cycle n+1.
- Back-to-back transfers: the next hit is sampled at the earliest in the cycle after select drops. Minimum spacing is 3 cycles.
- All outputs are registered. No combinational path runs from OPB inputs to outputs.

## Test plan
- Reset with C_RESET_VAL=32'hA5A5A5A5, N=8 -> all user_data_out words are A5A5A5A5, user_update=0, Sl_xferAck=0, and a read of STATUS returns 0.
- C_ATOMIC=0: write 0x12345678 to REG[3] with BE=1111 -> ack in the next cycle, word 3 = 0x12345678, user_update=0x08 for one cycle. A read of REG[3] returns 0x12345678 with ack. Sl_DBus is 0 outside ack.
- Byte enables: REG[0]=0xFFFFFFFF, then write 0x00000000 with BE=0101 -> REG[0]=0xFF00FF00.
- C_ATOMIC=1:
  - Write REG[1]=0x11 and REG[5]=0x55 -> outputs unchanged, STATUS reads 0x22.
  - Write COMMIT -> words 1 and 5 update at the same edge, user_update=0x22 for one cycle, STATUS reads 0.
- Select held high for 4 cycles -> exactly one ack. An address above C_HIGHADDR -> no ack. An in-window address past STATUS -> ack, read 0.
- Assert OPB_Rst_n low in the ACK cycle of a write to REG[2] -> Sl_xferAck drops immediately, and all registers read C_RESET_VAL after reset.
